// File: rtl/rtc_pkg.sv
// RTC memory-sync shared definitions.
// Packed time layout, boot default and FSM state encoding.
package rtc_pkg;

    localparam int SEC_LSB  = 0;
    localparam int SEC_W    = 6;
    localparam int MIN_LSB  = 6;
    localparam int MIN_W    = 6;
    localparam int RSVD_LSB = 12;
    localparam int RSVD_W   = 3;
    localparam int HOUR_LSB = 15;
    localparam int HOUR_W   = 5;
    localparam int DAY_LSB  = 20;
    localparam int DAY_W    = 6;
    localparam int YEAR_LSB = 26;
    localparam int YEAR_W   = 6;

    // year 1, day 1, 01:01:01
    localparam logic [31:0] TIME_DEFAULT = 32'h0410_8041;

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [RSVD_W-1:0] rsvd;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } rtc_time_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_RUN,
        ST_WR
    } rtc_state_e;

    // Out-of-range fields fall back to the boot default;
    // the reserved bits are always cleared on load.
    function automatic logic [31:0] rtc_sanitise(
        input logic [31:0] w,
        input logic [5:0]  day_max
    );
        rtc_time_t t;
        t = rtc_time_t'(w);
        t.rsvd = '0;
        if (t.sec > 6'd59 || t.min > 6'd59 ||
            t.hour > 5'd23 || t.day == 6'd0 ||
            t.day > day_max)
            return TIME_DEFAULT;
        return t;
    endfunction

endpackage

// File: rtl/rtc_time_inc.sv
// RTC one-second increment.
// Pure combinational sec->min->hour->day->year carry chain.
module rtc_time_inc
    import rtc_pkg::*;
#(
    parameter int DAY_MAX = 31
) (
    input  logic [31:0] time_in,
    output logic [31:0] time_out
);

    localparam logic [5:0] DAY_LAST = 6'(DAY_MAX);

    rtc_time_t t;
    rtc_time_t n;
    logic      c_min;
    logic      c_hour;
    logic      c_day;
    logic      c_year;

    // Ripple the carry through each field; year wraps naturally at 63.
    always_comb begin
        t      = rtc_time_t'(time_in);
        n      = t;
        n.rsvd = '0;

        c_min  = (t.sec == 6'd59);
        c_hour = c_min && (t.min == 6'd59);
        c_day  = c_hour && (t.hour == 5'd23);
        c_year = c_day && (t.day == DAY_LAST);

        n.sec = c_min ? 6'd0 : t.sec + 6'd1;

        if (c_min)
            n.min = c_hour ? 6'd0 : t.min + 6'd1;

        if (c_hour)
            n.hour = c_day ? 5'd0 : t.hour + 5'd1;

        if (c_day)
            n.day = c_year ? 6'd1 : t.day + 6'd1;

        if (c_year)
            n.year = t.year + 6'd1;
    end

    assign time_out = n;

endmodule

// File: rtl/rtc_mem_sync.sv
// RTC with boot-time restore and periodic writeback.
// Reads the packed time from memory, keeps it running, writes it back.
module rtc_mem_sync
    import rtc_pkg::*;
#(
    parameter int         CLKS_PER_SEC = 100,
    parameter logic [7:0] RTC_ADDR     = 8'd1,
    parameter int         WB_PERIOD    = 60,
    parameter int         DAY_MAX      = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_valid,
    input  logic [31:0] set_time,
    output logic        set_ready,
    output logic [31:0] time_out,
    output logic        time_valid,
    output logic [7:0]  mem_addr,
    output logic        mem_ce,
    output logic        mem_sel,
    output logic        mem_pwrite,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam int PW =
        (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam int WW = $clog2(WB_PERIOD + 1);

    localparam logic [PW-1:0] PRESC_LAST =
        PW'(CLKS_PER_SEC - 1);
    localparam logic [WW-1:0] WB_LAST =
        WW'(WB_PERIOD - 1);
    localparam logic [5:0] DAY_LAST = 6'(DAY_MAX);

    rtc_state_e    state_q;
    logic [31:0]   time_q;
    logic [31:0]   time_nxt;
    logic [PW-1:0] presc_q;
    logic [WW-1:0] wb_q;

    logic          valid_q;
    logic          ready_q;
    logic          ce_q;
    logic          sel_q;
    logic          pwr_q;
    logic [7:0]    addr_q;

    logic          running;
    logic          tick;
    logic          set_fire;
    logic          wb_hit;

    assign running  = (state_q == ST_RUN) ||
                      (state_q == ST_WR);
    assign tick     = running && (presc_q == PRESC_LAST);
    assign set_fire = set_valid && ready_q;
    assign wb_hit   = (state_q == ST_RUN) && tick &&
                      (wb_q == WB_LAST);

    rtc_time_inc #(
        .DAY_MAX (DAY_MAX)
    ) u_inc (
        .time_in  (time_q),
        .time_out (time_nxt)
    );

    // Time register, prescaler and writeback counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_q  <= '0;
            presc_q <= '0;
            wb_q    <= '0;
        end else begin
            if (state_q == ST_CAP)
                time_q <= rtc_sanitise(mem_rd_data, DAY_LAST);
            else if (set_fire)
                time_q <= rtc_sanitise(set_time, DAY_LAST);
            else if (tick)
                time_q <= time_nxt;

            if (!running || set_fire || tick)
                presc_q <= '0;
            else
                presc_q <= presc_q + PW'(1);

            if (!running || set_fire || wb_hit)
                wb_q <= '0;
            else if (tick && state_q == ST_RUN)
                wb_q <= wb_q + WW'(1);
        end
    end

    // Sequencer with registered memory and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            ce_q    <= 1'b0;
            sel_q   <= 1'b1;
            pwr_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_RD;
                    ce_q    <= 1'b1;
                    sel_q   <= 1'b0;
                    pwr_q   <= 1'b0;
                    addr_q  <= RTC_ADDR;
                end
                ST_RD: begin
                    state_q <= ST_CAP;
                    ce_q    <= 1'b0;
                    sel_q   <= 1'b1;
                    addr_q  <= '0;
                end
                ST_CAP: begin
                    state_q <= ST_RUN;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                end
                ST_RUN: begin
                    if (set_fire || wb_hit) begin
                        state_q <= ST_WR;
                        ready_q <= 1'b0;
                        ce_q    <= 1'b1;
                        sel_q   <= 1'b0;
                        pwr_q   <= 1'b1;
                        addr_q  <= RTC_ADDR;
                    end
                end
                ST_WR: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                    ce_q    <= 1'b0;
                    sel_q   <= 1'b1;
                    pwr_q   <= 1'b0;
                    addr_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                    ce_q    <= 1'b0;
                    sel_q   <= 1'b1;
                    pwr_q   <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    // Reset forces idle values at once so an in-flight
    // write never completes at the reset edge.
    assign time_out    = rst ? '0 : time_q;
    assign time_valid  = valid_q & ~rst;
    assign set_ready   = ready_q & ~rst;
    assign mem_ce      = ce_q & ~rst;
    assign mem_sel     = sel_q | rst;
    assign mem_pwrite  = pwr_q & ~rst;
    assign mem_addr    = rst ? '0 : addr_q;
    assign mem_wr_data = (pwr_q & ~rst) ? time_q : '0;

endmodule

// File: tb/tb_rtc_mem_sync.sv
// Directed bench for rtc_mem_sync.
// Small word memory model, hand-computed expected times.
module tb_rtc_mem_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_valid = 1'b0;
    logic [31:0] set_time = '0;
    logic        set_ready;
    logic [31:0] time_out;
    logic        time_valid;
    logic [7:0]  mem_addr;
    logic        mem_ce;
    logic        mem_sel;
    logic        mem_pwrite;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rtc_mem_sync #(
        .CLKS_PER_SEC (4),
        .RTC_ADDR     (8'd1),
        .WB_PERIOD    (2),
        .DAY_MAX      (31)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .set_valid   (set_valid),
        .set_time    (set_time),
        .set_ready   (set_ready),
        .time_out    (time_out),
        .time_valid  (time_valid),
        .mem_addr    (mem_addr),
        .mem_ce      (mem_ce),
        .mem_sel     (mem_sel),
        .mem_pwrite  (mem_pwrite),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // One-cycle-latency memory with a bench preload port.
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_ce && !mem_sel) begin
            if (mem_pwrite)
                mem[mem_addr] <= mem_wr_data;
            else
                mem_rd_data <= mem[mem_addr];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".time_out"}, time_out, 32'h0);
        chk({tag, ".time_valid"}, 32'(time_valid), 32'h0);
        chk({tag, ".set_ready"}, 32'(set_ready), 32'h0);
        chk({tag, ".mem_ce"}, 32'(mem_ce), 32'h0);
        chk({tag, ".mem_sel"}, 32'(mem_sel), 32'h1);
        chk({tag, ".mem_pwrite"}, 32'(mem_pwrite), 32'h0);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, ".mem_wr_data"}, mem_wr_data, 32'h0);
    endtask

    // Reset edge plus a preload of memory word 1.
    task automatic boot_with(input logic [31:0] w);
        rst      = 1'b1;
        pre_we   = 1'b1;
        pre_addr = 8'd1;
        pre_data = w;
        step(1);
        pre_we   = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and boot with a valid stored time
        boot_with(32'h0410_8041);
        rst = 1'b1;
        step(1);
        chk_reset_outs("rst");
        rst = 1'b0;
        step(1);
        chk("boot.rd_ce", 32'(mem_ce), 32'h1);
        chk("boot.rd_sel", 32'(mem_sel), 32'h0);
        chk("boot.rd_pwrite", 32'(mem_pwrite), 32'h0);
        chk("boot.rd_addr", 32'(mem_addr), 32'h1);
        chk("boot.rd_valid", 32'(time_valid), 32'h0);
        step(1);
        chk("boot.cap_ce", 32'(mem_ce), 32'h0);
        chk("boot.cap_addr", 32'(mem_addr), 32'h0);
        step(1);
        chk("boot.time", time_out, 32'h0410_8041);
        chk("boot.valid", 32'(time_valid), 32'h1);
        chk("boot.ready", 32'(set_ready), 32'h1);

        // Full carry: 23:59:59 day 31 year 5 -> year 6 day 1
        boot_with(32'h15FB_8EFB);
        step(3);
        chk("tick.load", time_out, 32'h15FB_8EFB);
        step(3);
        chk("tick.hold", time_out, 32'h15FB_8EFB);
        step(1);
        chk("tick.carry", time_out, 32'h1810_0000);

        // Writeback after two seconds (8 RUN cycles total)
        step(3);
        chk("wb.not_yet", 32'(mem_pwrite), 32'h0);
        step(1);
        chk("wb.pwrite", 32'(mem_pwrite), 32'h1);
        chk("wb.ce", 32'(mem_ce), 32'h1);
        chk("wb.sel", 32'(mem_sel), 32'h0);
        chk("wb.addr", 32'(mem_addr), 32'h1);
        chk("wb.data", mem_wr_data, 32'h1810_0001);
        chk("wb.ready", 32'(set_ready), 32'h0);
        step(1);
        chk("wb.done", 32'(mem_pwrite), 32'h0);
        chk("wb.mem", mem[1], 32'h1810_0001);
        chk("wb.mem_eq_time", mem[1], time_out);

        // Valid set: 12:34:56 day 15 year 2
        set_valid = 1'b1;
        set_time  = 32'h08F6_08B8;
        step(1);
        set_valid = 1'b0;
        chk("set.time", time_out, 32'h08F6_08B8);
        chk("set.wr", 32'(mem_pwrite), 32'h1);
        chk("set.wr_data", mem_wr_data, 32'h08F6_08B8);
        step(1);
        chk("set.mem", mem[1], 32'h08F6_08B8);
        step(2);
        chk("set.presc_hold", time_out, 32'h08F6_08B8);
        step(1);
        chk("set.presc_tick", time_out, 32'h08F6_08B9);
        chk("set.no_wb", 32'(mem_pwrite), 32'h0);

        // Set coinciding with a tick; day 0 is sanitised
        step(3);
        set_valid = 1'b1;
        set_time  = 32'h0C00_F000;
        step(1);
        set_valid = 1'b0;
        chk("prec.time", time_out, 32'h0410_8041);
        chk("prec.wr", 32'(mem_pwrite), 32'h1);

        // Reset in the middle of the WR cycle
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_wr");
        step(1);
        chk("rst_wr.mem", mem[1], 32'h08F6_08B8);
        rst = 1'b0;
        step(1);
        chk("rst_wr.reread_ce", 32'(mem_ce), 32'h1);
        chk("rst_wr.reread_pw", 32'(mem_pwrite), 32'h0);
        chk("rst_wr.reread_addr", 32'(mem_addr), 32'h1);
        step(2);
        chk("rst_wr.time", time_out, 32'h08F6_08B8);
        chk("rst_wr.valid", 32'(time_valid), 32'h1);

        // Garbage stored word is replaced by the default
        boot_with(32'hFFFF_FFFF);
        step(3);
        chk("san.time", time_out, 32'h0410_8041);

        // Reset while RD is in flight, then clean reboot
        boot_with(32'h15FB_8EFB);
        step(1);
        chk("rst_rd.rd", 32'(mem_ce), 32'h1);
        rst = 1'b1;
        step(1);
        chk("rst_rd.time", time_out, 32'h0);
        chk("rst_rd.valid", 32'(time_valid), 32'h0);
        rst = 1'b0;
        step(3);
        chk("rst_rd.reboot", time_out, 32'h15FB_8EFB);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
